// File: rtl/cnn_conv_engine.sv
// Streamed-frame 3x3 CNN engine: NUM_FILT filters, ReLU, global-sum pool, argmax.
// Optional CNN_BIAS_EN adds a per-filter bias preloaded into each position's accumulator.
module cnn_conv_engine #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int DATA_W   = 8,
    parameter int WT_W     = 8,
    parameter int NUM_FILT = 4,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    input  logic [DATA_W-1:0]               pix_data,
    input  logic                            wt_we,
    input  logic [$clog2(NUM_FILT*10)-1:0]  wt_addr,
    input  logic signed [WT_W-1:0]          wt_data,
    output logic                            busy,
    output logic [OUT_W-1:0]                value,
    output logic [ACC_W-1:0]                max_score,
    output logic                            done
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int PA_W  = $clog2(NPIX);
    localparam int NW    = NUM_FILT * 9;
    localparam int WI_W  = $clog2(NW);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int FW    = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
    localparam int PW    = DATA_W + WT_W + 1;
    localparam logic [ACC_W-1:0] POOL_MAX = {1'b0, {(ACC_W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CONV, S_POOL, S_CMP, S_DONE
    } state_t;

    state_t                   state_q;
    logic                     pix_ready_q, busy_q, done_q;
    logic [OUT_W-1:0]         value_q;
    logic [ACC_W-1:0]         max_q;
    logic [PA_W-1:0]          cnt_q;
    logic [XW-1:0]            ox_q;
    logic [YW-1:0]            oy_q;
    logic [1:0]               kx_q, ky_q;
    logic [FW-1:0]            filt_q, idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]         pool_q, best_q;

    logic [DATA_W-1:0]        fb_q [NPIX];
    logic signed [WT_W-1:0]   wts_q [NW];

    logic [PA_W-1:0]          rd_addr;
    logic [WI_W-1:0]          wi;
    logic signed [PW-1:0]     px_s, wt_s, prod;
    logic signed [ACC_W-1:0]  prod_x, acc_init, relu;
    logic [ACC_W:0]           psum;
    logic [ACC_W-1:0]         pool_d;
    logic                     first_tap, last_tap, last_pos, last_filt;

`ifdef CNN_BIAS_EN
    logic signed [WT_W-1:0]   bias_q [NUM_FILT];
    assign acc_init = {{(ACC_W-WT_W){bias_q[filt_q][WT_W-1]}}, bias_q[filt_q]};
`else
    assign acc_init = '0;
`endif

    always_comb begin
        rd_addr = PA_W'((int'(oy_q) + int'(ky_q)) * IMG_W + int'(ox_q) + int'(kx_q));
        wi      = WI_W'(int'(filt_q) * 9 + int'(ky_q) * 3 + int'(kx_q));
        // pixel is unsigned: zero-extend, weight sign-extend, then multiply
        px_s    = {{(PW-DATA_W){1'b0}}, fb_q[rd_addr]};
        wt_s    = {{(PW-WT_W){wts_q[wi][WT_W-1]}}, wts_q[wi]};
        prod    = px_s * wt_s;
        prod_x  = {{(ACC_W-PW){prod[PW-1]}}, prod};
        relu    = acc_q[ACC_W-1] ? '0 : acc_q;
        psum    = {1'b0, pool_q} + {1'b0, relu};
        pool_d  = (psum > {1'b0, POOL_MAX}) ? POOL_MAX : psum[ACC_W-1:0];
        first_tap = (kx_q == 2'd0) && (ky_q == 2'd0);
        last_tap  = (kx_q == 2'd2) && (ky_q == 2'd2);
        last_pos  = (ox_q == XW'(IMG_W-3)) && (oy_q == YW'(IMG_H-3));
        last_filt = (filt_q == FW'(NUM_FILT-1));
    end

    always_ff @(posedge clk) begin
        if (pix_ready_q && pix_valid) begin
            fb_q[cnt_q] <= pix_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wt_we && !busy_q) begin
            if (int'(wt_addr) < NW) begin
                wts_q[WI_W'(wt_addr)] <= wt_data;
            end
`ifdef CNN_BIAS_EN
            else if (int'(wt_addr) < NUM_FILT*10) begin
                bias_q[FW'(int'(wt_addr) - NW)] <= wt_data;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pix_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            value_q     <= '0;
            max_q       <= '0;
            cnt_q       <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            filt_q      <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            pool_q      <= '0;
            best_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q     <= S_LOAD;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                    end
                end
                S_LOAD: begin
                    if (pix_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == PA_W'(NPIX-1)) begin
                            state_q     <= S_CONV;
                            pix_ready_q <= 1'b0;
                            ox_q        <= '0;
                            oy_q        <= '0;
                            kx_q        <= '0;
                            ky_q        <= '0;
                            filt_q      <= '0;
                            pool_q      <= '0;
                        end
                    end
                end
                S_CONV: begin
                    acc_q <= (first_tap ? acc_init : acc_q) + prod_x;
                    if (kx_q == 2'd2) begin
                        kx_q <= '0;
                        ky_q <= (ky_q == 2'd2) ? 2'd0 : ky_q + 2'd1;
                    end else begin
                        kx_q <= kx_q + 2'd1;
                    end
                    if (last_tap) begin
                        state_q <= S_POOL;
                    end
                end
                S_POOL: begin
                    pool_q <= pool_d;
                    if (ox_q == XW'(IMG_W-3)) begin
                        ox_q <= '0;
                        oy_q <= (oy_q == YW'(IMG_H-3)) ? '0 : oy_q + 1'b1;
                    end else begin
                        ox_q <= ox_q + 1'b1;
                    end
                    state_q <= last_pos ? S_CMP : S_CONV;
                end
                S_CMP: begin
                    // strict compare keeps the lower index on ties
                    if (filt_q == '0 || pool_q > best_q) begin
                        best_q <= pool_q;
                        idx_q  <= filt_q;
                    end
                    pool_q <= '0;
                    if (last_filt) begin
                        state_q <= S_DONE;
                    end else begin
                        filt_q  <= filt_q + 1'b1;
                        state_q <= S_CONV;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    value_q <= OUT_W'(idx_q);
                    max_q   <= best_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pix_ready = pix_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign value     = value_q;
    assign max_score = max_q;
endmodule

// File: tb/tb_cnn_conv_engine.sv
// Directed bench for cnn_conv_engine with a result scoreboard.
module tb_cnn_conv_engine;
    localparam int IMG_W    = 8;
    localparam int IMG_H    = 8;
    localparam int DATA_W   = 8;
    localparam int WT_W     = 8;
    localparam int NUM_FILT = 4;
    localparam int ACC_W    = 32;
    localparam int OUT_W    = 32;
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int NADDR    = NUM_FILT * 10;
    localparam int WA_W     = $clog2(NADDR);
    localparam int LAT      = NUM_FILT * ((IMG_H-2)*(IMG_W-2)*10 + 1) + 1;
    localparam longint MAXP = (64'd1 << (ACC_W-1)) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    enable;
    logic                    pix_valid;
    logic                    pix_ready;
    logic [DATA_W-1:0]       pix_data;
    logic                    wt_we;
    logic [WA_W-1:0]         wt_addr;
    logic signed [WT_W-1:0]  wt_data;
    logic                    busy;
    logic [OUT_W-1:0]        value;
    logic [ACC_W-1:0]        max_score;
    logic                    done;

    always #5 clk = ~clk;

    cnn_conv_engine #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .WT_W(WT_W),
        .NUM_FILT(NUM_FILT), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .busy(busy), .value(value), .max_score(max_score), .done(done)
    );

    typedef struct {
        int     v;
        longint s;
        int     lat;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                t0;
    int                wt_m [NADDR];
    logic [DATA_W-1:0] frame [NPIX];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int v, input longint s);
        exp_t e;
        e.v = v; e.s = s; e.lat = LAT;
        sb.push_back(e);
    endtask

    // Reference convolution over the bench's own weight/frame copies
    function automatic void model(output int v, output longint s);
        longint best, pool, acc;
        best = 0; v = 0;
        for (int f = 0; f < NUM_FILT; f++) begin
            pool = 0;
            for (int oy = 0; oy < IMG_H-2; oy++)
                for (int ox = 0; ox < IMG_W-2; ox++) begin
                    acc = 0;
`ifdef CNN_BIAS_EN
                    acc = wt_m[NUM_FILT*9 + f];
`endif
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++)
                            acc += longint'(int'(frame[(oy+ky)*IMG_W + ox + kx]))
                                   * wt_m[f*9 + ky*3 + kx];
                    if (acc > 0) pool += acc;
                    if (pool > MAXP) pool = MAXP;
                end
            if (f == 0 || pool > best) begin
                best = pool; v = f;
            end
        end
        s = best;
    endfunction

    task automatic write_wt(input int addr, input int data);
        @(negedge clk);
        wt_we = 1'b1; wt_addr = WA_W'(addr); wt_data = WT_W'(data);
        @(negedge clk);
        wt_we = 1'b0;
        if (addr < NADDR) wt_m[addr] = data;
    endtask

    task automatic clear_wts();
        for (int a = 0; a < NADDR; a++) write_wt(a, 0);
    endtask

    task automatic load_frame(input bit stall);
        int   n = 0;
        int   k = 0;
        logic hs;
        @(negedge clk); enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        while (n < NPIX && k < 4*NPIX) begin
            pix_valid = !stall || (k % 2 == 0);
            pix_data  = frame[n];
            k++;
            hs = pix_valid && pix_ready;
            @(posedge clk);
            if (hs) n++;
            @(negedge clk);
        end
        t0 = cyc;
        pix_valid = 1'b0;
        check("accepts", 64'(n), 64'(NPIX));
        check("ready_low_after_load", 64'(pix_ready), 64'd0);
        check("busy_in_run", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        exp_t e;
        bit   seen = 1'b0;
        for (int i = 0; i < 4*LAT && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("value", 64'(value), 64'(e.v));
            check("max_score", 64'(max_score), 64'(e.s));
            check("latency", 64'(cyc - t0), 64'(e.lat));
        end else begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
        end
        @(negedge clk);
        check("done_pulse_len", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic run(input bit stall);
        load_frame(stall);
        wait_done();
    endtask

    initial begin
        int     mv;
        longint ms;
        rst = 1'b0; enable = 1'b0; pix_valid = 1'b0; pix_data = '0;
        wt_we = 1'b0; wt_addr = '0; wt_data = '0;
        for (int a = 0; a < NADDR; a++) wt_m[a] = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ready", 64'(pix_ready), 64'd0);
        check("rst_value", 64'(value), 64'd0);
        check("rst_score", 64'(max_score), 64'd0);
        rst = 1'b1;

        // filter 2 all ones, all-ones frame; weight write while busy must be dropped
        clear_wts();
        for (int t = 0; t < 9; t++) write_wt(2*9 + t, 1);
        for (int i = 0; i < NPIX; i++) frame[i] = 8'd1;
        push(2, 324);
        load_frame(1'b0);
        @(negedge clk);
        wt_we = 1'b1; wt_addr = WA_W'(18); wt_data = 8'sd100;
        repeat (4) @(negedge clk);
        wt_we = 1'b0;
        wait_done();

        // same frame with a stalling source
        push(2, 324);
        run(1'b1);

        // reset while convolving, then a fresh run with retained weights
        load_frame(1'b0);
        repeat (100) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_value", 64'(value), 64'd0);
        check("abort_score", 64'(max_score), 64'd0);
        rst = 1'b1;
        push(2, 324);
        run(1'b0);

        // all weights -1: ReLU zeroes every pool, tie goes to filter 0
        for (int a = 0; a < NUM_FILT*9; a++) write_wt(a, -1);
        push(0, 0);
        run(1'b0);

        // centre taps on filters 1 and 3, ramp frame
        clear_wts();
        write_wt(1*9 + 4, 1);
        write_wt(3*9 + 4, 2);
        for (int i = 0; i < NPIX; i++) frame[i] = DATA_W'(i % 256);
        push(3, 2 * 1134);
        run(1'b0);

        // filter 0 bias only
        clear_wts();
        write_wt(NUM_FILT*9, 5);
        for (int i = 0; i < NPIX; i++) frame[i] = 8'd1;
`ifdef CNN_BIAS_EN
        push(0, 180);
`else
        push(0, 0);
`endif
        run(1'b0);

        // random small weights and frame against the reference model
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < NUM_FILT*9; a++)
                write_wt(a, int'($urandom_range(0, 6)) - 3);
            for (int f = 0; f < NUM_FILT; f++)
                write_wt(NUM_FILT*9 + f, int'($urandom_range(0, 20)) - 10);
            for (int i = 0; i < NPIX; i++)
                frame[i] = DATA_W'($urandom_range(0, 255));
            model(mv, ms);
            push(mv, ms);
            run(r[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
